// File: rtl/score_bcd_sequencer_pkg.sv
// Shared definitions for the score display path.
// Holds the conversion FSM state type, the ASCII code used by the text renderer
// for the digit '0', and a ceil(log2) helper for deriving register widths.
package score_bcd_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Renderer forms a digit character as ASCII_ZERO + nibble.
  localparam int unsigned ASCII_ZERO = 48;

  // Number of bits needed to hold values 0..value-1 (minimum 1).
  // For the score width use logb2(H*V); for a counter reaching N use logb2(N+1).
  function automatic int unsigned logb2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble adjust cell: adds 3 to a BCD nibble that is 5 or more so the
// following left shift carries correctly into the next decimal digit.
// Ports:
//   i_nib   - BCD nibble before the shift
//   o_nib_c - adjusted nibble (combinational)
module bcd_add3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib_c
);

  assign o_nib_c = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/score_bcd_sequencer.sv
// Once-per-frame binary-to-BCD converter for the score display.
// A frame_start pulse in IDLE with a changed score captures the score and runs
// SCORE_BITS add-3/shift steps, then commits all digits together in one edge so
// the renderer never sees a mix of old and new digits.
// Ports:
//   clk         - system/pixel clock
//   rst         - synchronous active-high reset
//   score       - binary score, sampled only on an accepted frame_start
//   frame_start - one-cycle pulse at start of vertical blanking
//   busy        - conversion in progress
//   done        - one-cycle pulse when new digits are committed
//   digits      - registered BCD, [3:0] units
module score_bcd_sequencer
  import score_bcd_sequencer_pkg::*;
#(
  parameter int unsigned SCORE_BITS = 10,
  parameter int unsigned DIGITS     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SCORE_BITS-1:0]   score,
  input  logic                    frame_start,
  output logic                    busy,
  output logic                    done,
  output logic [4*DIGITS-1:0]     digits
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = logb2(SCORE_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(SCORE_BITS - 1);

  state_t                  r_state;
  logic [SCORE_BITS-1:0]   r_bin;
  logic [BCD_W-1:0]        r_bcd;
  logic [CNT_W-1:0]        r_cnt;
  logic [SCORE_BITS-1:0]   r_cap;
  logic [SCORE_BITS-1:0]   r_last_score;
  logic                    r_busy;
  logic                    r_done;
  logic [BCD_W-1:0]        r_digits;

  logic [BCD_W-1:0]            w_adj;
  logic [BCD_W+SCORE_BITS-1:0] w_shift;

  // Per-digit add-3 adjust ahead of the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_nib   (r_bcd[4*g +: 4]),
      .o_nib_c (w_adj[4*g +: 4])
    );
  end

  // Adjusted digits and remaining binary bits shift left together as one register.
  assign w_shift = {w_adj, r_bin} << 1;

  // Conversion FSM and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_bin        <= '0;
      r_bcd        <= '0;
      r_cnt        <= '0;
      r_cap        <= '0;
      r_last_score <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_digits     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // An unchanged score needs no work; the display already shows it.
          if (frame_start && (score != r_last_score)) begin
            r_bin   <= score;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_cap   <= score;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          {r_bcd, r_bin} <= w_shift;
          r_cnt          <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_SHIFT) r_state <= COMMIT;
        end
        COMMIT: begin
          r_digits     <= r_bcd;
          r_last_score <= r_cap;
          r_done       <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign digits = r_digits;

endmodule
